// File: rtl/stack_pkg.sv
// Shared constants and helpers for the LIFO stack.
// Holds the default WIDTH/DEPTH and the count-width function.
package stack_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Occupancy count must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: synchronous write, indexed (combinational) read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module stack_mem
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack.sv
// LIFO stack top: count, accept logic, registered dout, flags.
// Ports: clk, rstn (async active-high), push, pop, din, dout,
// empty, full; overflow/underflow with STACK_ERR_FLAGS_EN.
module stack
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
`ifdef STACK_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [CW-1:0]    count;
    logic [CW-1:0]    top_idx;
    logic             wr_en;
    logic             rd_en;
    logic             inc;
    logic             dec;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] rdata;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign top_idx = count - CW'(1);

    // With pop high a push always writes: either it overwrites
    // the top (non-empty) or it is a plain push into an empty stack.
    assign wr_en = push & (pop | ~full);
    assign rd_en = pop & ~empty;
    assign inc   = wr_en & ~rd_en;
    assign dec   = rd_en & ~wr_en;

    // Simultaneous push/pop replaces the top in place.
    assign waddr = rd_en ? top_idx[AW-1:0] : count[AW-1:0];

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (waddr),
        .wdata (din),
        .raddr (top_idx[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            count <= '0;
        end else begin
            unique case (1'b1)
                inc:     count <= count + CW'(1);
                dec:     count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            dout <= '0;
        end else if (rd_en) begin
            dout <= rdata;
        end
    end

`ifdef STACK_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push & ~pop & full;
            underflow <= pop & ~push & empty;
        end
    end
`endif

endmodule

// File: tb/tb_stack.sv
// Scoreboard bench for stack: queue-based LIFO reference model.
// Build with or without STACK_ERR_FLAGS_EN.
module tb_stack;

    localparam int W = 8;
    localparam int D = 8;

    typedef struct {
        logic [W-1:0] dout;
        logic         empty;
        logic         full;
        logic         ov;
        logic         un;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         push = 1'b0;
    logic         pop = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout;
    logic         empty;
    logic         full;
`ifdef STACK_ERR_FLAGS_EN
    logic         overflow;
    logic         underflow;
`endif

    int total = 0;
    int bad = 0;

    logic [W-1:0] mdl[$];
    logic [W-1:0] mdout = '0;
    exp_t         exp_q[$];

    stack #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .empty (empty),
        .full  (full)
`ifdef STACK_ERR_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    // One clock edge of stimulus; the model computes the result
    // from LIFO rules and queues it for the monitor.
    task automatic step(input logic p, input logic q,
                        input logic [W-1:0] d);
        exp_t e;
        @(negedge clk);
        push = p;
        pop  = q;
        din  = d;
        e.ov = 1'b0;
        e.un = 1'b0;
        if (p && q && mdl.size() > 0) begin
            mdout = mdl[mdl.size()-1];
            mdl[mdl.size()-1] = d;
        end else if (p && q) begin
            mdl.push_back(d);
        end else if (p) begin
            if (mdl.size() < D) mdl.push_back(d);
            else e.ov = 1'b1;
        end else if (q) begin
            if (mdl.size() > 0) mdout = mdl.pop_back();
            else e.un = 1'b1;
        end
        e.dout  = mdout;
        e.empty = (mdl.size() == 0);
        e.full  = (mdl.size() == D);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0);
    endtask

    task automatic drain_q();
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_dout"}, 32'(dout), 32'h0);
        check({tag, "_empty"}, 32'(empty), 32'h1);
        check({tag, "_full"}, 32'(full), 32'h0);
`ifdef STACK_ERR_FLAGS_EN
        check({tag, "_ovf"}, 32'(overflow), 32'h0);
        check({tag, "_unf"}, 32'(underflow), 32'h0);
`endif
    endtask

    // Monitor: outputs settle after each edge; compare there.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (!rstn && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("dout", 32'(dout), 32'(e.dout));
            check("empty", 32'(empty), 32'(e.empty));
            check("full", 32'(full), 32'(e.full));
`ifdef STACK_ERR_FLAGS_EN
            check("overflow", 32'(overflow), 32'(e.ov));
            check("underflow", 32'(underflow), 32'(e.un));
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] fill[8];
        fill = '{8'h11, 8'h22, 8'h33, 8'h44,
                 8'h11, 8'h22, 8'h33, 8'h44};
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("rst_hold");
        @(negedge clk);
        rstn = 1'b0;

        foreach (fill[i]) begin
            step(1'b1, 1'b0, fill[i]);
            idle();
        end
        step(1'b1, 1'b0, 8'h55);
        idle();
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 8'hAA);
        step(1'b1, 1'b0, 8'hBB);
        step(1'b0, 1'b1, '0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
        idle();
        step(1'b0, 1'b1, '0);
        idle();

        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b1, 8'h77);
        step(1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 8'h5A);
        idle();
        drain_q();
        check("sb_drain1", 32'(exp_q.size()), 32'h0);

        @(negedge clk);
        #2;
        rstn = 1'b1;
        #1;
        check_reset_outs("rst_async");
        mdl.delete();
        mdout = '0;
        @(posedge clk);
        #1;
        check_reset_outs("rst_edge");
        @(negedge clk);
        rstn = 1'b0;

        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 40)      step(1'b1, 1'b0, W'($urandom));
            else if (r < 75) step(1'b0, 1'b1, '0);
            else if (r < 90) step(1'b1, 1'b1, W'($urandom));
            else             idle();
        end
        idle();
        drain_q();
        check("sb_drain2", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
